// File: rtl/m_mem_port_arbiter_if.sv
// m_mem_port_arbiter_if: request, ack and DRAM command/busy bundle between the PTW, DMA, arbiter and DRAM
//   ptw_*  page-walker request (req/we/addr/wdata in, ack/rdata out)
//   dma_*  DMA loader request, same rules
//   dram_* single DRAM port: one-cycle req strobe with we/addr/wdata, busy/rdata back
//   owner/busy  last grant (0 PTW, 1 DMA) and arbiter-active status
interface m_mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              i_ptw_req;
  logic              i_ptw_we;
  logic [ADDR_W-1:0] i_ptw_addr;
  logic [DATA_W-1:0] i_ptw_wdata;
  logic              o_ptw_ack;
  logic [DATA_W-1:0] o_ptw_rdata;
  logic              i_dma_req;
  logic              i_dma_we;
  logic [ADDR_W-1:0] i_dma_addr;
  logic [DATA_W-1:0] i_dma_wdata;
  logic              o_dma_ack;
  logic [DATA_W-1:0] o_dma_rdata;
  logic              o_dram_req;
  logic              o_dram_we;
  logic [ADDR_W-1:0] o_dram_addr;
  logic [DATA_W-1:0] o_dram_wdata;
  logic              i_dram_busy;
  logic [DATA_W-1:0] i_dram_rdata;
  logic              o_owner;
  logic              o_busy;
  modport slave (
    input  i_ptw_req, i_ptw_we, i_ptw_addr, i_ptw_wdata,
    input  i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
    input  i_dram_busy, i_dram_rdata,
    output o_ptw_ack, o_ptw_rdata, o_dma_ack, o_dma_rdata,
    output o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata,
    output o_owner, o_busy
  );
  modport master (
    output i_ptw_req, i_ptw_we, i_ptw_addr, i_ptw_wdata,
    output i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
    output i_dram_busy, i_dram_rdata,
    input  o_ptw_ack, o_ptw_rdata, o_dma_ack, o_dma_rdata,
    input  o_dram_req, o_dram_we, o_dram_addr, o_dram_wdata,
    input  o_owner, o_busy
  );
endinterface

// File: rtl/m_mem_port_arbiter.sv
// m_mem_port_arbiter: PTW-priority, starvation-bounded arbiter serialising PTW and DMA onto one DRAM port
//   CLK, RST  clock and asynchronous active-high reset
//   bus       m_mem_port_arbiter_if.slave (requesters, DRAM command/busy, owner/busy status)
module m_mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic CLK,
  input logic RST,
  m_mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            state, nxt;
  logic              we_q, owner_q, seen, start, pick_dma, finish, act;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, ptw_rd, dma_rd;
  logic [CW-1:0]     cnt;
  always_comb begin
    pick_dma = bus.i_dma_req && (!bus.i_ptw_req || cnt == CW'(STARVE_LIMIT));
    start    = (bus.i_ptw_req || bus.i_dma_req) && !bus.i_dram_busy;
    // seen guards against treating the pre-command low busy as completion
    finish   = seen && !bus.i_dram_busy;
    nxt      = state == IDLE  ? (start  ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (finish ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else     state <= nxt;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_q    <= 1'b0;
      owner_q <= 1'b0;
      seen    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ptw_rd  <= '0;
      dma_rd  <= '0;
      cnt     <= '0;
    end else begin
      if (state == IDLE && start) begin
        owner_q <= pick_dma;
        we_q    <= pick_dma ? bus.i_dma_we    : bus.i_ptw_we;
        addr_q  <= pick_dma ? bus.i_dma_addr  : bus.i_ptw_addr;
        wdata_q <= pick_dma ? bus.i_dma_wdata : bus.i_ptw_wdata;
      end
      if (state == IDLE)
        cnt <= !bus.i_dma_req ? '0 : !start ? cnt : pick_dma ? '0 :
               cnt == CW'(STARVE_LIMIT) ? cnt : cnt + CW'(1);
      if (state == ISSUE) seen <= 1'b0;
      else if (state == WAIT && bus.i_dram_busy) seen <= 1'b1;
      if (state == WAIT && finish && !we_q && owner_q)  dma_rd <= bus.i_dram_rdata;
      if (state == WAIT && finish && !we_q && !owner_q) ptw_rd <= bus.i_dram_rdata;
    end
  end
  assign act              = state == ISSUE || state == WAIT;
  assign bus.o_dram_req   = state == ISSUE;
  assign bus.o_dram_we    = act && we_q;
  assign bus.o_dram_addr  = act ? addr_q : '0;
  assign bus.o_dram_wdata = act ? wdata_q : '0;
  assign bus.o_ptw_ack    = state == DONE && !owner_q;
  assign bus.o_dma_ack    = state == DONE && owner_q;
  assign bus.o_ptw_rdata  = ptw_rd;
  assign bus.o_dma_rdata  = dma_rd;
  assign bus.o_owner      = owner_q;
  assign bus.o_busy       = state != IDLE;
endmodule
